// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: computes the result at issue, holds it in a pending
// register for the op latency, then commits it to HI/LO with a one-cycle done pulse.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  logic               done_q, done_d;

  logic               op_signed, is_div, a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, product, acc, result;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;
  logic [CW-1:0]      latency;

  // Even op codes (mult, div, madd, msub) are the signed variants.
  always_comb begin
    op_signed = ~md_op[0];
    is_div    = (md_op == 4'd2) || (md_op == 4'd3);
    a_ext     = op_signed ? {{WIDTH{src_a[WIDTH-1]}}, src_a} : {{WIDTH{1'b0}}, src_a};
    b_ext     = op_signed ? {{WIDTH{src_b[WIDTH-1]}}, src_b} : {{WIDTH{1'b0}}, src_b};
    product   = a_ext * b_ext;
    acc       = {hi_q, lo_q};
    a_neg     = op_signed & src_a[WIDTH-1];
    b_neg     = op_signed & src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
    b_safe    = (b_mag == '0) ? WIDTH'(1) : b_mag;
    q_mag     = a_mag / b_safe;
    r_mag     = a_mag % b_safe;
    // Most-negative / -1 wraps back to src_a with zero remainder without special casing.
    quot      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem       = a_neg ? -r_mag : r_mag;
    if (b_mag == '0) begin
      quot = '1;
      rem  = src_a;
    end
    latency = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    case (md_op)
      4'd0, 4'd1: result = product;
      4'd2, 4'd3: result = {rem, quot};
      4'd4, 4'd5: result = acc + product;
      4'd6, 4'd7: result = acc - product;
      default:    result = product;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (md_op <= 4'd7) begin
            pend_d  = result;
            cnt_d   = latency;
            state_d = BUSY;
          end else if (md_op == 4'd8) begin
            hi_d = src_a;
          end else if (md_op == 4'd9) begin
            lo_d = src_a;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = pend_q;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: per-cycle comparison against an arithmetic reference model
// plus directed vectors with hand-computed literals, and a 16-bit single-cycle instance.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, done, dbg_state;
  logic [31:0] hi, lo;

  logic        s_start;
  logic [3:0]  s_op;
  logic [15:0] s_a, s_b;
  logic        s_busy, s_done, s_dbg;
  logic [15:0] s_hi, s_lo;

  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  mult_div_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .md_op(s_op), .src_a(s_a), .src_b(s_b),
    .busy(s_busy), .done(s_done), .hi(s_hi), .lo(s_lo), .dbg_state(s_dbg)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_pend;
  logic [63:0] m_res;
  int          m_acc, m_lat, cyc;

  function automatic logic [63:0] md_result(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] acc_v);
    longint      sa, sb;
    logic [63:0] smul, umul;
    int          q, r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smul = 64'(sa * sb);
    umul = {32'h0, a} * {32'h0, b};
    case (op)
      4'd0: return smul;
      4'd1: return umul;
      4'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
      4'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      4'd4: return acc_v + smul;
      4'd5: return acc_v + umul;
      4'd6: return acc_v - smul;
      default: return acc_v - umul;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_done = 0; m_pend = 0; cyc = 0; m_res = 0; m_acc = 0; m_lat = 0;
    end else begin
      if (start && !m_pend) begin
        if (md_op <= 4'd7) begin
          m_res  = md_result(md_op, src_a, src_b, {m_hi, m_lo});
          m_pend = 1;
          m_acc  = cyc;
          m_lat  = (md_op == 4'd2 || md_op == 4'd3) ? 10 : 5;
        end else if (md_op == 4'd8) begin
          m_hi = src_a;
        end else if (md_op == 4'd9) begin
          m_lo = src_a;
        end
      end
      cyc++;
      m_done = 0;
      if (m_pend && cyc == m_acc + m_lat + 1) begin
        {m_hi, m_lo} = m_res;
        m_done = 1;
        m_pend = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cyc_busy",  64'(busy),      64'(m_pend));
    check("cyc_state", 64'(dbg_state), 64'(m_pend));
    check("cyc_done",  64'(done),      64'(m_done));
    check("cyc_hi",    64'(hi),        64'(m_hi));
    check("cyc_lo",    64'(lo),        64'(m_lo));
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] eh, input logic [31:0] el,
                        input string nm);
    int n;
    bit seen;
    issue(op, a, b);
    n = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) n++;
    end
    check({nm, "_done"}, 64'(seen), 64'd1);
    check({nm, "_busy_cycles"}, 64'(n), 64'(exp_n));
    check({nm, "_hi"}, 64'(hi), 64'(eh));
    check({nm, "_lo"}, 64'(lo), 64'(el));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit seen;
    reset = 1'b1; start = 1'b0; md_op = 4'd0; src_a = 0; src_b = 0;
    s_start = 1'b0; s_op = 4'd0; s_a = 0; s_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // mthi / mtlo
    issue(4'd8, 32'h1234, 32'h0);
    issue(4'd9, 32'hABCD, 32'h0);
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mtlo_lo", 64'(lo), 64'hABCD);
    check("mtx_busy", 64'(busy), 64'd0);
    check("mtx_done", 64'(done), 64'd0);

    // unused op codes leave HI/LO alone
    issue(4'd12, 32'hDEAD_BEEF, 32'h5);
    @(negedge clk);
    check("op12_hi", 64'(hi), 64'h1234);
    check("op12_busy", 64'(busy), 64'd0);

    run_op(4'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    run_op(4'd3, 32'd7, 32'd0, 10, 32'd7, 32'hFFFF_FFFF, "divu_zero");
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_ovf");
    run_op(4'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD, "div_negb");
    run_op(4'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu");
    run_op(4'd2, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF, "div_zero");

    // accumulate group
    issue(4'd8, 32'h0, 32'h0);
    issue(4'd9, 32'hFFFF_FFFF, 32'h0);
    run_op(4'd5, 32'd1, 32'd1, 5, 32'd1, 32'd0, "maddu");
    run_op(4'd6, 32'd1, 32'd2, 5, 32'd0, 32'hFFFF_FFFE, "msub");
    run_op(4'd4, 32'hFFFF_FFFF, 32'd3, 5, 32'd0, 32'hFFFF_FFFB, "madd");
    run_op(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'd2, 32'hFFFF_FFFA, "msubu");

    // start while busy is ignored
    issue(4'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; md_op = 4'd9; src_a = 32'h55;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("ign_done", 64'(seen), 64'd1);
    check("ign_lo", 64'(lo), 64'd14);
    check("ign_hi", 64'(hi), 64'd2);

    // reset mid-operation
    issue(4'd0, 32'd3, 32'd4);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hi",   64'(hi),   64'd0);
    check("mid_rst_lo",   64'(lo),   64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) n++;
    end
    check("mid_rst_no_done", 64'(n), 64'd0);
    check("mid_rst_lo_after", 64'(lo), 64'd0);

    // 16-bit instance, single-cycle multiply
    @(posedge clk); #1;
    s_start = 1'b1; s_op = 4'd0; s_a = 16'h8000; s_b = 16'h8000;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    check("w16_mult_busy", 64'(s_busy), 64'd1);
    check("w16_mult_early_done", 64'(s_done), 64'd0);
    @(negedge clk);
    check("w16_mult_done", 64'(s_done), 64'd1);
    check("w16_mult_busy_off", 64'(s_busy), 64'd0);
    check("w16_mult_hi", 64'(s_hi), 64'h4000);
    check("w16_mult_lo", 64'(s_lo), 64'h0000);

    @(posedge clk); #1;
    s_start = 1'b1; s_op = 4'd1; s_a = 16'hFFFF; s_b = 16'hFFFF;
    @(posedge clk); #1;
    s_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("w16_multu_done", 64'(s_done), 64'd1);
    check("w16_multu_hi", 64'(s_hi), 64'hFFFE);
    check("w16_multu_lo", 64'(s_lo), 64'h0001);

    @(posedge clk); #1;
    s_start = 1'b1; s_op = 4'd2; s_a = 16'h8000; s_b = 16'hFFFF;
    @(posedge clk); #1;
    s_start = 1'b0;
    n = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (s_done) seen = 1;
      else if (s_busy) n++;
    end
    check("w16_div_done", 64'(seen), 64'd1);
    check("w16_div_busy_cycles", 64'(n), 64'd3);
    check("w16_div_lo", 64'(s_lo), 64'h8000);
    check("w16_div_hi", 64'(s_hi), 64'h0000);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
